// File: rtl/sb_rx_deser_decoder.sv
// Sideband RX: deserializes LSB-first 64-bit words, detects the init pattern, decodes header(+data) packets.
// Latency: message/error pulses 1 cycle after the final bit; no backpressure, every sampled bit is consumed.
module sb_rx_deser_decoder #(
  parameter logic [63:0] PATTERN      = 64'h5555_5555_5555_5555,
  parameter int          PATTERN_ITER = 2,
  parameter int          DATA_TIMEOUT = 128,
  parameter logic [4:0]  OPC_DATA     = 5'b11011,
  parameter logic [4:0]  OPC_NODATA   = 5'b10010
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ser_valid,
  input  logic        i_ser_data,
  input  logic        i_pattern_mode,
  output logic        o_pattern_detected,
  output logic        o_pattern_locked,
  output logic        o_msg_valid,
  output logic [61:0] o_header,
  output logic [63:0] o_data,
  output logic        o_has_data,
  output logic        o_parity_err,
  output logic        o_frame_err,
  output logic        o_busy
);

  localparam int PCW = $clog2(PATTERN_ITER + 1);
  localparam int TCW = $clog2(DATA_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, PAT, HDR_WAIT_DATA} state_t;

  state_t         state_q, state_d;
  logic [63:0]    shreg_q;
  logic [5:0]     bit_cnt_q;
  logic           mode_q;
  logic [PCW-1:0] pat_cnt_q, pat_cnt_d, pat_inc;
  logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [63:0]    hdr_q, hdr_d;

  logic [63:0]    word;
  logic           word_done, broken, pat_match, hdr_cp_err, held_cp_err;
  logic           msg_d, ferr_d, det_d, perr_d, locked_d, has_data_d;
  logic [61:0]    header_d;
  logic [63:0]    data_d;

  // The bit being sampled this cycle completes the word combinationally, so decode costs no extra cycle.
  assign word        = {i_ser_data, shreg_q[63:1]};
  assign word_done   = i_ser_valid && (bit_cnt_q == 6'd63);
  assign broken      = !i_ser_valid && (bit_cnt_q != 6'd0);
  assign pat_match   = (word == PATTERN);
  assign pat_inc     = (pat_cnt_q == PCW'(PATTERN_ITER)) ? pat_cnt_q : pat_cnt_q + PCW'(1);
  assign hdr_cp_err  = (^word[61:0]) != word[62];
  assign held_cp_err = (^hdr_q[61:0]) != hdr_q[62];
  assign o_busy      = (bit_cnt_q != 6'd0) || (state_q == HDR_WAIT_DATA);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      mode_q    <= 1'b0;
    end else if (i_ser_valid) begin
      shreg_q   <= word;
      bit_cnt_q <= bit_cnt_q + 6'd1;
      if (bit_cnt_q == 6'd0) mode_q <= i_pattern_mode;
    end else begin
      bit_cnt_q <= '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    pat_cnt_d  = pat_cnt_q;
    tmo_cnt_d  = '0;
    hdr_d      = hdr_q;
    msg_d      = 1'b0;
    ferr_d     = 1'b0;
    det_d      = 1'b0;
    perr_d     = 1'b0;
    locked_d   = o_pattern_locked;
    header_d   = o_header;
    data_d     = o_data;
    has_data_d = o_has_data;
    case (state_q)
      IDLE: begin
        if (word_done) begin
          if (mode_q) begin
            if (pat_match) begin
              pat_cnt_d = pat_inc;
              if (pat_inc == PCW'(PATTERN_ITER)) begin
                det_d    = 1'b1;
                locked_d = 1'b1;
                state_d  = PAT;
              end
            end else begin
              pat_cnt_d = '0;
            end
          end else if (word[4:0] == OPC_NODATA) begin
            msg_d      = 1'b1;
            header_d   = word[61:0];
            data_d     = '0;
            has_data_d = 1'b0;
            perr_d     = hdr_cp_err | word[63];
          end else if (word[4:0] == OPC_DATA) begin
            hdr_d   = word;
            state_d = HDR_WAIT_DATA;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      PAT: begin
        if (word_done && mode_q) pat_cnt_d = pat_match ? pat_inc : '0;
      end
      HDR_WAIT_DATA: begin
        if (word_done) begin
          msg_d      = 1'b1;
          header_d   = hdr_q[61:0];
          data_d     = word;
          has_data_d = 1'b1;
          perr_d     = held_cp_err | ((^word) != hdr_q[63]);
          state_d    = IDLE;
        end else if (!i_ser_valid) begin
          tmo_cnt_d = tmo_cnt_q + TCW'(1);
          if (tmo_cnt_d == TCW'(DATA_TIMEOUT)) begin
            ferr_d    = 1'b1;
            state_d   = IDLE;
            tmo_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (broken) begin
      ferr_d    = 1'b1;
      state_d   = IDLE;
      tmo_cnt_d = '0;
    end
    // Leaving pattern mode always unlocks, whatever word is in flight.
    if (!i_pattern_mode) begin
      locked_d  = 1'b0;
      pat_cnt_d = '0;
      if (state_d == PAT) state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q            <= IDLE;
      pat_cnt_q          <= '0;
      tmo_cnt_q          <= '0;
      hdr_q              <= '0;
      o_pattern_detected <= 1'b0;
      o_pattern_locked   <= 1'b0;
      o_msg_valid        <= 1'b0;
      o_header           <= '0;
      o_data             <= '0;
      o_has_data         <= 1'b0;
      o_parity_err       <= 1'b0;
      o_frame_err        <= 1'b0;
    end else begin
      state_q            <= state_d;
      pat_cnt_q          <= pat_cnt_d;
      tmo_cnt_q          <= tmo_cnt_d;
      hdr_q              <= hdr_d;
      o_pattern_detected <= det_d;
      o_pattern_locked   <= locked_d;
      o_msg_valid        <= msg_d;
      o_header           <= header_d;
      o_data             <= data_d;
      o_has_data         <= has_data_d;
      o_parity_err       <= perr_d;
      o_frame_err        <= ferr_d;
    end
  end

endmodule

// File: tb/tb_sb_rx_deser_decoder.sv
// Randomized scoreboard bench for sb_rx_deser_decoder with a word-level reference model.
module tb_sb_rx_deser_decoder;

  localparam logic [63:0] PATTERN      = 64'h5555_5555_5555_5555;
  localparam int          PATTERN_ITER = 2;
  localparam int          DATA_TIMEOUT = 128;
  localparam logic [4:0]  OPC_DATA     = 5'b11011;
  localparam logic [4:0]  OPC_NODATA   = 5'b10010;
  localparam logic [2:0]  K_MSG        = 3'b001;
  localparam logic [2:0]  K_FERR       = 3'b010;
  localparam logic [2:0]  K_DET        = 3'b100;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_ser_valid = 1'b0;
  logic        i_ser_data = 1'b0;
  logic        i_pattern_mode = 1'b0;
  logic        o_pattern_detected, o_pattern_locked, o_msg_valid;
  logic [61:0] o_header;
  logic [63:0] o_data;
  logic        o_has_data, o_parity_err, o_frame_err, o_busy;

  sb_rx_deser_decoder #(
    .PATTERN(PATTERN), .PATTERN_ITER(PATTERN_ITER), .DATA_TIMEOUT(DATA_TIMEOUT),
    .OPC_DATA(OPC_DATA), .OPC_NODATA(OPC_NODATA)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ser_valid(i_ser_valid), .i_ser_data(i_ser_data),
    .i_pattern_mode(i_pattern_mode), .o_pattern_detected(o_pattern_detected),
    .o_pattern_locked(o_pattern_locked), .o_msg_valid(o_msg_valid), .o_header(o_header),
    .o_data(o_data), .o_has_data(o_has_data), .o_parity_err(o_parity_err),
    .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  kind;
    int          cyc;
    logic [61:0] hdr;
    logic [63:0] data;
    logic        has;
    logic        perr;
  } ev_t;

  ev_t exp_q[$];
  ev_t e;
  int  n_chk = 0;
  int  n_pass = 0;
  int  last_cyc;

  // Reference model state, tracked per whole word.
  int          m_pcnt = 0;
  bit          m_inpat = 0;
  bit          m_locked = 0;
  bit          m_pend = 0;
  logic [63:0] m_hdr = '0;
  int          m_idle = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input logic [2:0] k, input int c, input logic [61:0] h,
                      input logic [63:0] d, input logic has, input logic perr);
    ev_t x;
    x.kind = k; x.cyc = c; x.hdr = h; x.data = d; x.has = has; x.perr = perr;
    exp_q.push_back(x);
  endtask

  function automatic logic [63:0] mk_hdr(input logic [4:0] opc, input bit cp_ok, input bit dp);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    r[4:0] = opc;
    r[62] = (^r[61:0]) ^ ~cp_ok;
    r[63] = dp;
    return r;
  endfunction

  task automatic send_word(input logic [63:0] w);
    for (int i = 0; i < 64; i++) begin
      @(negedge i_clk);
      i_ser_valid = 1'b1;
      i_ser_data  = w[i];
    end
    m_idle   = 0;
    last_cyc = cyc;
  endtask

  task automatic idle_step();
    @(negedge i_clk);
    i_ser_valid = 1'b0;
    i_ser_data  = 1'b0;
    if (m_pend) begin
      m_idle++;
      if (m_idle == DATA_TIMEOUT) begin
        push(K_FERR, cyc + 1, '0, '0, 1'b0, 1'b0);
        m_pend = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) idle_step();
  endtask

  task automatic set_mode(input bit m);
    @(negedge i_clk);
    i_ser_valid    = 1'b0;
    i_pattern_mode = m;
    if (!m) begin
      m_pcnt = 0; m_inpat = 0; m_locked = 0;
    end
    idle(2);
  endtask

  task automatic pat_word(input logic [63:0] w);
    send_word(w);
    if (w == PATTERN) begin
      if (m_pcnt < PATTERN_ITER) m_pcnt++;
      if (!m_inpat && m_pcnt == PATTERN_ITER) begin
        push(K_DET, last_cyc + 1, '0, '0, 1'b0, 1'b0);
        m_inpat = 1; m_locked = 1;
      end
    end else begin
      m_pcnt = 0;
    end
  endtask

  task automatic pkt_word(input logic [63:0] w);
    send_word(w);
    if (m_pend) begin
      push(K_MSG, last_cyc + 1, m_hdr[61:0], w, 1'b1, (^m_hdr[62:0]) | ((^w) != m_hdr[63]));
      m_pend = 0;
    end else if (w[4:0] == OPC_NODATA) begin
      push(K_MSG, last_cyc + 1, w[61:0], '0, 1'b0, (^w[62:0]) | w[63]);
    end else if (w[4:0] == OPC_DATA) begin
      m_pend = 1; m_hdr = w; m_idle = 0;
    end else begin
      push(K_FERR, last_cyc + 1, '0, '0, 1'b0, 1'b0);
    end
  endtask

  task automatic broken_word(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge i_clk);
      i_ser_valid = 1'b1;
      i_ser_data  = 1'($urandom_range(0, 1));
    end
    @(negedge i_clk);
    i_ser_valid = 1'b0;
    push(K_FERR, cyc + 1, '0, '0, 1'b0, 1'b0);
    m_pend = 0; m_idle = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({o_pattern_detected, o_pattern_locked, o_msg_valid, o_has_data,
                              o_parity_err, o_frame_err, o_busy}), 64'd0);
    check({tag, "_header"}, 64'(o_header), 64'd0);
    check({tag, "_data"}, o_data, 64'd0);
  endtask

  logic [2:0] act;
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("event_latency", 64'(cyc), 64'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
      act = {o_pattern_detected, o_frame_err, o_msg_valid};
      if (act != 3'b000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 64'(act), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", 64'(act), 64'(e.kind));
          check("event_cycle", 64'(cyc), 64'(e.cyc));
          if (e.kind == K_MSG) begin
            check("msg_header", 64'(o_header), 64'(e.hdr));
            check("msg_data", o_data, e.data);
            check("msg_has_data", 64'(o_has_data), 64'(e.has));
            check("msg_parity_err", 64'(o_parity_err), 64'(e.perr));
          end else if (e.kind == K_DET) begin
            check("det_locked", 64'(o_pattern_locked), 64'd1);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d, h, w;
    logic [4:0]  opc;
    int          sel;

    #12;
    check_all_zero("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(2);

    // Pattern detect: three back-to-back patterns, detect on the second
    set_mode(1'b1);
    for (int i = 0; i < 3; i++) pat_word(PATTERN);
    idle_step();
    check("locked_after_detect", 64'(o_pattern_locked), 64'(m_locked));
    set_mode(1'b0);
    check("locked_after_mode_drop", 64'(o_pattern_locked), 64'd0);

    // Pattern restart after a one-bit mismatch
    set_mode(1'b1);
    pat_word(PATTERN);
    pat_word(64'h5555_5555_5555_5554);
    pat_word(PATTERN);
    idle(3);
    check("no_lock_after_restart", 64'(o_pattern_locked), 64'd0);
    pat_word(PATTERN);
    idle_step();
    check("locked_after_restart", 64'(o_pattern_locked), 64'd1);
    set_mode(1'b0);

    // Header-only, then header+data with good and flipped DP, back-to-back
    pkt_word(mk_hdr(OPC_NODATA, 1'b1, 1'b0));
    d = 64'hDEAD_BEEF_0123_4567;
    pkt_word(mk_hdr(OPC_DATA, 1'b1, ^d));
    idle_step();
    check("busy_waiting_data", 64'(o_busy), 64'd1);
    pkt_word(d);
    pkt_word(mk_hdr(OPC_DATA, 1'b1, ~(^d)));
    pkt_word(d);
    idle(2);

    // Broken word, data timeout, and one cycle short of timeout
    broken_word(40);
    idle(2);
    check("busy_after_broken", 64'(o_busy), 64'd0);
    pkt_word(mk_hdr(OPC_DATA, 1'b1, 1'b0));
    idle(DATA_TIMEOUT + 2);
    check("busy_after_timeout", 64'(o_busy), 64'd0);
    pkt_word(mk_hdr(OPC_NODATA, 1'b1, 1'b0));
    d = {$urandom(), $urandom()};
    pkt_word(mk_hdr(OPC_DATA, 1'b1, ^d));
    idle(DATA_TIMEOUT - 1);
    pkt_word(d);
    idle(2);

    // Randomized mix
    for (int it = 0; it < 100; it++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        set_mode(1'b1);
        for (int k = 0; k < $urandom_range(1, 4); k++) begin
          w = PATTERN;
          if ($urandom_range(0, 3) == 0) w = w ^ (64'd1 << $urandom_range(0, 63));
          pat_word(w);
        end
        idle_step();
        check("rand_locked", 64'(o_pattern_locked), 64'(m_locked));
        set_mode(1'b0);
      end else if (sel < 5) begin
        pkt_word(mk_hdr(OPC_NODATA, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0));
      end else if (sel < 8) begin
        d = {$urandom(), $urandom()};
        pkt_word(mk_hdr(OPC_DATA, $urandom_range(0, 3) != 0, (^d) ^ ($urandom_range(0, 3) == 0)));
        idle($urandom_range(0, 5));
        pkt_word(d);
      end else if (sel == 8) begin
        do opc = 5'($urandom_range(0, 31)); while (opc == OPC_DATA || opc == OPC_NODATA);
        pkt_word(mk_hdr(opc, 1'b1, 1'b0));
      end else begin
        broken_word($urandom_range(1, 63));
      end
      idle($urandom_range(0, 2));
    end
    idle(3);

    // Reset during bit 30 of a data word
    d = {$urandom(), $urandom()};
    pkt_word(mk_hdr(OPC_NODATA, 1'b1, 1'b0));
    pkt_word(mk_hdr(OPC_DATA, 1'b1, ^d));
    for (int i = 0; i < 30; i++) begin
      @(negedge i_clk);
      i_ser_valid = 1'b1;
      i_ser_data  = d[i];
    end
    @(negedge i_clk);
    i_rst_n     = 1'b0;
    i_ser_valid = 1'b0;
    #1;
    check_all_zero("midreset");
    m_pend = 0; m_idle = 0; m_pcnt = 0; m_inpat = 0; m_locked = 0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(2);
    pkt_word(mk_hdr(OPC_DATA, 1'b1, ^d));
    pkt_word(d);
    idle(4);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
